// File: rtl/pipelined_adder_tree.sv
// Signed pipelined reduction tree with valid/ready handshake and optional multi-beat accumulation.
// Optional macro PIPELINED_ADDER_TREE_SAT_EN: saturating accumulation plus sticky out_sat port.
module pipelined_adder_tree #(
   parameter int DATA_WIDTH = 16,
   parameter int LENGTH     = 5,
   parameter int ACC_EXTRA  = 8,
   parameter int CNT_WIDTH  = 8,
   localparam int OUT_WIDTH = DATA_WIDTH + $clog2(LENGTH) + ACC_EXTRA
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH*LENGTH-1:0] in_addends,
   input  logic                         in_acc,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_sum,
   output logic [CNT_WIDTH-1:0]         out_beats
`ifdef PIPELINED_ADDER_TREE_SAT_EN
   ,
   output logic                         out_sat
`endif
);

   localparam int LEVELS     = ($clog2(LENGTH) < 1) ? 1 : $clog2(LENGTH);
   localparam int TREE_WIDTH = DATA_WIDTH + LEVELS;
   localparam int EXT_WIDTH  = (TREE_WIDTH > OUT_WIDTH) ? TREE_WIDTH : OUT_WIDTH;

   typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   function automatic int cnt_at(input int k);
      int n;
      n = LENGTH;
      for (int i = 0; i < k; i++) n = (n + 1) / 2;
      return n;
   endfunction

`ifdef PIPELINED_ADDER_TREE_SAT_EN
   function automatic logic acc_ovf(input logic [OUT_WIDTH-1:0] a, input logic [OUT_WIDTH-1:0] b);
      logic [OUT_WIDTH-1:0] s;
      s = a + b;
      return (a[OUT_WIDTH-1] == b[OUT_WIDTH-1]) && (s[OUT_WIDTH-1] != a[OUT_WIDTH-1]);
   endfunction

   function automatic logic [OUT_WIDTH-1:0] acc_add(input logic [OUT_WIDTH-1:0] a, input logic [OUT_WIDTH-1:0] b);
      logic [OUT_WIDTH-1:0] s;
      s = a + b;
      if (acc_ovf(a, b)) begin
         s = a[OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else begin
         s = a + b;
      end
      return s;
   endfunction
`else
   function automatic logic [OUT_WIDTH-1:0] acc_add(input logic [OUT_WIDTH-1:0] a, input logic [OUT_WIDTH-1:0] b);
      return a + b;
   endfunction
`endif

   logic en_s;
   logic out_valid_r;
   logic [OUT_WIDTH-1:0] out_sum_r;
   logic [CNT_WIDTH-1:0] out_beats_r;

   // A stalled result blocks every stage, so a bubble never gets squeezed out.
   assign en_s      = !(out_valid_r && !out_ready);
   assign in_ready  = en_s;
   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;
   assign out_beats = out_beats_r;

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int N_IN  = cnt_at(k - 1);
      localparam int N_OUT = cnt_at(k);
      localparam int W_IN  = DATA_WIDTH + k - 1;
      localparam int W     = DATA_WIDTH + k;
      logic [N_IN*W_IN-1:0] src_s;
      logic                 src_valid_s, src_acc_s, src_last_s;
      logic [N_OUT*W-1:0]   nxt_s;
      logic [N_OUT*W-1:0]   data_r;
      logic                 valid_r, acc_r, last_r;

      if (k == 1) begin : g_src
         assign src_s       = in_addends;
         assign src_valid_s = in_valid;
         assign src_acc_s   = in_acc;
         assign src_last_s  = in_last;
      end else begin : g_src
         assign src_s       = g_lvl[k-1].data_r;
         assign src_valid_s = g_lvl[k-1].valid_r;
         assign src_acc_s   = g_lvl[k-1].acc_r;
         assign src_last_s  = g_lvl[k-1].last_r;
      end

      for (genvar j = 0; j < N_OUT; j++) begin : g_elem
         logic [W_IN-1:0] a_s;
         assign a_s = src_s[W_IN*(2*j) +: W_IN];
         if (2*j + 1 < N_IN) begin : g_pair
            logic [W_IN-1:0] b_s;
            assign b_s = src_s[W_IN*(2*j+1) +: W_IN];
            assign nxt_s[W*j +: W] = {a_s[W_IN-1], a_s} + {b_s[W_IN-1], b_s};
         end else begin : g_pass
            assign nxt_s[W*j +: W] = {a_s[W_IN-1], a_s};
         end
      end

      // Tree level register: partial sums plus the beat's control bits.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            acc_r   <= 1'b0;
            last_r  <= 1'b0;
         end else if (en_s) begin
            data_r  <= nxt_s;
            valid_r <= src_valid_s;
            acc_r   <= src_acc_s;
            last_r  <= src_last_s;
         end
      end
   end

   logic [TREE_WIDTH-1:0] tree_s;
   logic [EXT_WIDTH-1:0]  tree_wide_s;
   logic [OUT_WIDTH-1:0]  tree_ext_s;
   logic                  tv_s, tree_acc_s, tree_last_s;

   assign tree_s      = g_lvl[LEVELS].data_r;
   assign tv_s        = g_lvl[LEVELS].valid_r;
   assign tree_acc_s  = g_lvl[LEVELS].acc_r;
   assign tree_last_s = g_lvl[LEVELS].last_r;
   assign tree_wide_s = EXT_WIDTH'($signed(tree_s));
   assign tree_ext_s  = tree_wide_s[OUT_WIDTH-1:0];

   state_t               state_r, state_nxt_s;
   logic [OUT_WIDTH-1:0] acc_r, acc_nxt_s, emit_sum_s, add_s;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s, cnt_inc_s, emit_beats_s;
   logic                 emit_s;

   assign add_s     = acc_add(acc_r, tree_ext_s);
   assign cnt_inc_s = (cnt_r == {CNT_WIDTH{1'b1}}) ? cnt_r : cnt_r + CNT_WIDTH'(1);

   // Output FSM next state: decides whether the tree result is emitted or folded into the accumulator.
   always_comb begin
      state_nxt_s  = state_r;
      acc_nxt_s    = acc_r;
      cnt_nxt_s    = cnt_r;
      emit_s       = 1'b0;
      emit_sum_s   = tree_ext_s;
      emit_beats_s = CNT_WIDTH'(1);
      if (tv_s) begin
         case (state_r)
            IDLE: begin
               if (tree_acc_s && !tree_last_s) begin
                  acc_nxt_s   = tree_ext_s;
                  cnt_nxt_s   = CNT_WIDTH'(1);
                  state_nxt_s = ACCUM;
               end else begin
                  emit_s = 1'b1;
               end
            end
            ACCUM: begin
               if (!tree_acc_s) begin
                  // Standalone beat inside a group: flush the partial sum, drop the beat.
                  emit_s       = 1'b1;
                  emit_sum_s   = acc_r;
                  emit_beats_s = cnt_r;
                  acc_nxt_s    = '0;
                  cnt_nxt_s    = '0;
                  state_nxt_s  = IDLE;
               end else if (!tree_last_s) begin
                  acc_nxt_s = add_s;
                  cnt_nxt_s = cnt_inc_s;
               end else begin
                  emit_s       = 1'b1;
                  emit_sum_s   = add_s;
                  emit_beats_s = cnt_inc_s;
                  acc_nxt_s    = '0;
                  cnt_nxt_s    = '0;
                  state_nxt_s  = IDLE;
               end
            end
            default: begin
               acc_nxt_s   = '0;
               cnt_nxt_s   = '0;
               state_nxt_s = IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Output FSM state, accumulator and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         cnt_r       <= '0;
         out_valid_r <= 1'b0;
         out_sum_r   <= '0;
         out_beats_r <= '0;
      end else if (en_s) begin
         state_r     <= state_nxt_s;
         acc_r       <= acc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= emit_s;
         if (emit_s) begin
            out_sum_r   <= emit_sum_s;
            out_beats_r <= emit_beats_s;
         end
      end
   end

`ifdef PIPELINED_ADDER_TREE_SAT_EN
   logic sat_r, sat_nxt_s, emit_sat_s, out_sat_r, add_ovf_s;

   assign add_ovf_s = acc_ovf(acc_r, tree_ext_s);
   assign out_sat   = out_sat_r;

   // Sticky saturation flag for the group currently being accumulated.
   always_comb begin
      sat_nxt_s  = sat_r;
      emit_sat_s = 1'b0;
      if (tv_s) begin
         case (state_r)
            IDLE: begin
               sat_nxt_s = 1'b0;
            end
            ACCUM: begin
               if (!tree_acc_s) begin
                  emit_sat_s = sat_r;
                  sat_nxt_s  = 1'b0;
               end else if (!tree_last_s) begin
                  sat_nxt_s = sat_r | add_ovf_s;
               end else begin
                  emit_sat_s = sat_r | add_ovf_s;
                  sat_nxt_s  = 1'b0;
               end
            end
            default: begin
               sat_nxt_s = 1'b0;
            end
         endcase
      end else begin
         sat_nxt_s = sat_r;
      end
   end

   // Saturation flag registers, held with the result during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_r     <= 1'b0;
         out_sat_r <= 1'b0;
      end else if (en_s) begin
         sat_r <= sat_nxt_s;
         if (emit_s) begin
            out_sat_r <= emit_sat_s;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: default instance plus an ACC_EXTRA=0 instance for overflow.
module tb_pipelined_adder_tree;

   localparam int DW   = 16;
   localparam int LEN  = 5;
   localparam int CW   = 8;
   localparam int OW   = DW + 3 + 8;
   localparam int OW_W = DW + 3;

   typedef struct {
      logic [OW-1:0] sum;
      logic [CW-1:0] beats;
   } exp_t;

   logic clk, rst_n;
   logic in_valid, in_ready, in_acc, in_last, out_valid, out_ready;
   logic [DW*LEN-1:0] in_addends;
   logic [OW-1:0] out_sum;
   logic [CW-1:0] out_beats;

   logic w_in_valid, w_in_ready, w_in_acc, w_in_last, w_out_valid, w_out_ready;
   logic [DW*LEN-1:0] w_in_addends;
   logic [OW_W-1:0] w_out_sum;
   logic [CW-1:0] w_out_beats;
`ifdef PIPELINED_ADDER_TREE_SAT_EN
   logic out_sat, w_out_sat;
`endif

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   pipelined_adder_tree #(.DATA_WIDTH(DW), .LENGTH(LEN), .ACC_EXTRA(8), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addends(in_addends), .in_acc(in_acc), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats)
`ifdef PIPELINED_ADDER_TREE_SAT_EN
      , .out_sat(out_sat)
`endif
   );

   pipelined_adder_tree #(.DATA_WIDTH(DW), .LENGTH(LEN), .ACC_EXTRA(0), .CNT_WIDTH(CW)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_addends(w_in_addends), .in_acc(w_in_acc), .in_last(w_in_last),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum), .out_beats(w_out_beats)
`ifdef PIPELINED_ADDER_TREE_SAT_EN
      , .out_sat(w_out_sat)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got sum=%0d beats=%0d, required no output",
                     $signed(out_sum), out_beats);
         end else begin
            mon_e = sb.pop_front();
            if (out_sum !== mon_e.sum || out_beats !== mon_e.beats) begin
               errors++;
               $display("FAIL result: got sum=%0d beats=%0d, required sum=%0d beats=%0d",
                        $signed(out_sum), out_beats, $signed(mon_e.sum), mon_e.beats);
            end
         end
      end
   end

   function automatic logic [DW*LEN-1:0] pack5(input int a0, input int a1, input int a2, input int a3, input int a4);
      int v[5];
      logic [DW*LEN-1:0] r;
      v = '{a0, a1, a2, a3, a4};
      r = '0;
      for (int i = 0; i < LEN; i++) r[DW*i +: DW] = DW'(v[i]);
      return r;
   endfunction

   task automatic push(input int sum, input int beats);
      exp_t e;
      e.sum   = OW'(sum);
      e.beats = CW'(beats);
      sb.push_back(e);
   endtask

   task automatic send(input logic [DW*LEN-1:0] a, input logic acc, input logic last);
      logic rdy;
      int guard;
      guard = 0;
      in_valid = 1'b1; in_addends = a; in_acc = acc; in_last = last;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         guard++;
         if (guard > 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", guard);
            break;
         end
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_sum: got %0d required 0", out_sum); end
      checks++; if (out_beats !== '0) begin errors++; $display("FAIL reset_beats: got %0d required 0", out_beats); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_standalone();
      int n;
      push(15, 1);
      send(pack5(1, 2, 3, 4, 5), 1'b0, 1'b0);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL latency: got %0d cycles required 4", n); end
      wait_drain();
   endtask

   task automatic test_signed();
      int v[5];
      int s;
      push(-163840, 1);
      send(pack5(-32768, -32768, -32768, -32768, -32768), 1'b0, 1'b0);
      push(0, 1);
      send(pack5(-1, 1, -1, 1, 0), 1'b0, 1'b0);
      for (int t = 0; t < 8; t++) begin
         s = 0;
         for (int i = 0; i < 5; i++) begin
            v[i] = int'($urandom_range(65535)) - 32768;
            s += v[i];
         end
         push(s, 1);
         send(pack5(v[0], v[1], v[2], v[3], v[4]), 1'b0, 1'b0);
      end
      wait_drain();
   endtask

   task automatic test_accum();
      push(15, 3);
      send(pack5(1, 1, 1, 1, 1), 1'b1, 1'b0);
      send(pack5(1, 1, 1, 1, 1), 1'b1, 1'b0);
      send(pack5(1, 1, 1, 1, 1), 1'b1, 1'b1);
      push(10, 1);
      send(pack5(2, 2, 2, 2, 2), 1'b1, 1'b1);
      push(6, 1);
      send(pack5(1, 2, 3, 0, 0), 1'b1, 1'b0);
      send(pack5(9, 9, 9, 9, 9), 1'b0, 1'b0);
      push(5, 1);
      send(pack5(5, 0, 0, 0, 0), 1'b0, 1'b1);
      wait_drain();
   endtask

   task automatic test_backpressure();
      logic [OW-1:0] held;
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(i, 1);
      fork
         begin
            for (int i = 1; i <= 6; i++) send(pack5(i, 0, 0, 0, 0), 1'b0, 1'b0);
         end
         begin
            int g;
            g = 0;
            while (!out_valid && g < 50) begin
               @(negedge clk);
               g++;
            end
            checks++;
            if (!out_valid) begin errors++; $display("FAIL stall_wait: out_valid=0 required 1"); end
            held = out_sum;
            checks++;
            if (held !== OW'(1)) begin errors++; $display("FAIL stall_first: got %0d required 1", held); end
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b required 0", in_ready); end
               checks++;
               if (out_sum !== held || out_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold: got sum=%0d valid=%b required sum=%0d valid=1", out_sum, out_valid, held);
               end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_reset_accum();
      send(pack5(3, 0, 0, 0, 0), 1'b1, 1'b0);
      send(pack5(4, 0, 0, 0, 0), 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", out_valid); end
      @(posedge clk); #1; rst_n = 1'b1;
      push(7, 1);
      send(pack5(7, 0, 0, 0, 0), 1'b0, 1'b0);
      wait_drain();
   endtask

   task automatic test_wrap_sat();
      int n;
      logic [OW_W-1:0] exp_sum;
      checks++;
      if (w_in_ready !== 1'b1) begin errors++; $display("FAIL w_ready: got %b required 1", w_in_ready); end
      w_in_addends = pack5(32767, 32767, 32767, 32767, 32767);
      w_in_acc = 1'b1; w_in_last = 1'b0; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_last = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 0;
      while (!w_out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!w_out_valid) begin errors++; $display("FAIL w_timeout: w_out_valid=0 required 1"); end
`ifdef PIPELINED_ADDER_TREE_SAT_EN
      exp_sum = {1'b0, {(OW_W-1){1'b1}}};
      checks++;
      if (w_out_sat !== 1'b1) begin errors++; $display("FAIL w_sat: got %b required 1", w_out_sat); end
`else
      exp_sum = OW_W'(327670);
`endif
      checks++;
      if (w_out_sum !== exp_sum) begin errors++; $display("FAIL w_sum: got %0d required %0d", $signed(w_out_sum), $signed(exp_sum)); end
      checks++;
      if (w_out_beats !== CW'(2)) begin errors++; $display("FAIL w_beats: got %0d required 2", w_out_beats); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      in_valid = 1'b0; in_addends = '0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      w_in_valid = 1'b0; w_in_addends = '0; w_in_acc = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_standalone();
      test_signed();
      test_accum();
      test_backpressure();
      test_reset_accum();
      test_wrap_sat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Successor to the combinational AdderTree in the RAWDNS PE: a signed, pipelined reduction tree with a valid/ready handshake on both sides.
- Optional multi-beat accumulation: partial dot-product sums from several input beats fold into one result.
- Sits between the PE multiplier array and the PE output buffer.
- Pipeline depth is parametrised. Backpressure from the output buffer stalls the whole pipeline.

Parameters:
- DATA_WIDTH, 16: width of each signed addend.
- LENGTH, 5: number of addends per beat; must be >= 1.
- ACC_EXTRA, 8: guard bits added for accumulation across beats.
- CNT_WIDTH, 8: width of the beat counter reported with each result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_addends  in  DATA_WIDTH*LENGTH  packed signed addends; addend i at [DATA_WIDTH*i +: DATA_WIDTH].
- in_acc  in  1  1 = accumulate this beat into the running sum; 0 = standalone beat.
- in_last  in  1  closes an accumulation group; ignored when in_acc=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_sum  out  OUT_WIDTH  signed result; OUT_WIDTH = DATA_WIDTH + clog2(LENGTH) + ACC_EXTRA.
- out_beats  out  CNT_WIDTH  number of beats summed into out_sum; 1 for standalone beats.

Behaviour:
- Reset: all stage valids, out_valid, out_sum, out_beats, the accumulator and the beat counter go to 0. in_ready = 1 after reset.
- Reset mid-operation: partial accumulation and all in-flight beats are discarded.
- Structure: L = max(1, clog2(LENGTH)) tree levels, each with a register stage (data, valid, acc, last), then one output stage.
- Tree arithmetic is sign-extended. Level k width is DATA_WIDTH + k.
- Odd element counts at a level pass the unpaired element through, registered.
- LENGTH=1 gives one pass-through register level.
- Stall: en = !(out_valid && !out_ready). All stage registers load only when en is high.
- in_ready = en, combinational.
- Bubbles are not compressed; a bubble advances like a beat.
- Latency with no stall: L+1 cycles from the accept edge to out_valid. Throughput is 1 beat/cycle.
- Output stage FSM, states IDLE and ACCUM, advancing only when en=1 and the tree-final valid (tv) is high:
  - IDLE, tv, acc=0: out_sum = sext(tree), out_beats = 1, out_valid = 1; stay IDLE.
  - IDLE, tv, acc=1, last=0: acc_reg = sext(tree), cnt = 1, no output; go to ACCUM.
  - IDLE, tv, acc=1, last=1: emit sext(tree), out_beats = 1; stay IDLE.
  - ACCUM, tv, acc=1, last=0: acc_reg += tree, cnt += 1 (saturates at all-ones); stay ACCUM.
  - ACCUM, tv, acc=1, last=1: emit acc_reg + tree, out_beats = cnt + 1 (saturating); clear acc_reg and cnt; go to IDLE.
  - ACCUM, tv, acc=0: protocol violation. Emit the current acc_reg with out_beats = cnt, clear acc_reg and cnt, go to IDLE. The standalone beat is dropped.
- When en=1 and no result is emitted this cycle, out_valid drops to 0.
- out_sum and out_beats are held stable while out_valid && !out_ready.
- Overflow of OUT_WIDTH wraps (two's complement) unless the optional feature is enabled.

Optional Feature:
- Macro: PIPELINED_ADDER_TREE_SAT_EN.
- Defined: accumulator additions saturate to the signed OUT_WIDTH range. Sticky output port out_sat (1 bit) is set for the emitted result if any add in its group saturated; out_sat resets to 0.
- Undefined: additions wrap and the out_sat port is absent.

Test Plan:
- Standalone beat: LENGTH=5, addends {1,2,3,4,5}, in_acc=0, out_ready=1 -> out_sum=15, out_beats=1, out_valid 4 cycles after accept (L=3).
- Signed operands: addends {-32768,-32768,-32768,-32768,-32768} -> out_sum=-163840 with correct sign extension; {-1,1,-1,1,0} -> 0.
- Accumulation: three beats of all-ones addends, in_acc=1, last on beat 3 -> exactly one result, out_sum=15, out_beats=3.
- Backpressure: 6 back-to-back beats {i,0,0,0,0} for i=1..6, out_ready held low 5 cycles -> in_ready low while stalled, no beat lost or duplicated, outputs 1..6 in order, out_sum stable during the stall.
- Reset during ACCUM: 2 beats accumulated, rst_n pulsed, then one standalone beat {7,0,0,0,0} -> out_sum=7, out_beats=1, no stale partial sum.
- SAT_EN with ACC_EXTRA=0: accumulate two beats of five 32767 addends -> out_sum = max positive of OUT_WIDTH, out_sat=1; without the macro the sum wraps.
